// File: rtl/game_pkg.sv
// Shared game-level types and screen constants for the Flappy Bird datapath.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam logic [9:0] PASS_X_DEFAULT = 10'd265;

    // Vertical play-field bounds, also used by the collision detector.
    localparam logic [9:0] SCREEN_Y_MIN = 10'd0;
    localparam logic [9:0] SCREEN_Y_MAX = 10'd480;

    // A pipe is cleared when its x steps from at/right of pass_x to left of it;
    // the low-to-high wrap can never satisfy this.
    function automatic logic crossed(input logic [9:0] prev_x,
                                     input logic [9:0] cur_x,
                                     input logic [9:0] pass_x);
        return (prev_x >= pass_x) && (cur_x < pass_x);
    endfunction

endpackage

// File: rtl/game_controller_rise_detect.sv
// Rising-edge detector for the start/flap key with a configurable reset value
// of the previous sample, so a key held through reset produces no edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge Clk) begin
        if (!Reset_n) prev <= RESET_VAL;
        else          prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/game_controller.sv
// Flappy Bird game FSM: start/restart, scoring, death freeze and high score.
// Build option: define GAME_HIGH_SCORE_EN to keep a high-score register.
//
// state | meaning
// IDLE  | waiting for first key press, objects frozen
// PLAY  | objects moving, pipe crossings score
// DYING | collision seen, frozen for DEATH_FRAMES frames
// OVER  | game over shown, key press restarts straight into PLAY
module game_controller
    import game_pkg::*;
#(
    parameter logic [7:0] DEATH_FRAMES = 8'd60,
    parameter int         SCORE_W      = 10,
    parameter logic [9:0] PASS_X       = PASS_X_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               start_key,
    input  logic               collision,
    input  logic [9:0]         pipe_x,
    output logic [1:0]         state,
    output logic               run_en,
    output logic               obj_reset,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               game_over
);

    game_state_t        state_q, state_d;
    logic [7:0]         death_cnt_q, death_cnt_d;
    logic [9:0]         pipe_x_prev;
    logic [SCORE_W-1:0] score_d;
    logic               key_rise;
    logic               crossing;
    logic               death_done;
    logic               obj_reset_d;

    rise_detect #(.RESET_VAL(1'b1)) u_key_rise (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .din     (start_key),
        .rise    (key_rise)
    );

    assign crossing   = frame_tick && crossed(pipe_x_prev, pipe_x, PASS_X);
    assign death_done = frame_tick && (death_cnt_q == DEATH_FRAMES - 8'd1);

    always_comb begin
        state_d     = state_q;
        death_cnt_d = death_cnt_q;
        score_d     = score;
        obj_reset_d = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (key_rise) begin
                    state_d     = PLAY;
                    obj_reset_d = 1'b1;
                    score_d     = '0;
                end
            end
            PLAY: begin
                // Collision takes priority over a crossing on the same cycle.
                if (collision) begin
                    state_d     = DYING;
                    death_cnt_d = '0;
                end else if (crossing && (score != '1)) begin
                    score_d = score + SCORE_W'(1);
                end
            end
            DYING: begin
                if (frame_tick) begin
                    death_cnt_d = death_cnt_q + 8'd1;
                    if (death_done) state_d = OVER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            death_cnt_q <= '0;
            pipe_x_prev <= '0;
            score       <= '0;
            run_en      <= 1'b0;
            obj_reset   <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state_q     <= state_d;
            death_cnt_q <= death_cnt_d;
            score       <= score_d;
            run_en      <= (state_d == PLAY);
            obj_reset   <= obj_reset_d;
            game_over   <= (state_d == OVER);
            if (frame_tick) pipe_x_prev <= pipe_x;
        end
    end

`ifdef GAME_HIGH_SCORE_EN
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            high_score <= '0;
        end else if ((state_q == DYING) && death_done && (score > high_score)) begin
            high_score <= score;
        end
    end
`else
    assign high_score = '0;
`endif

    assign state = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed scenarios plus a random
// run compared cycle by cycle against a behavioural game model.
module tb_game_controller;

    localparam int DF      = 3;
    localparam int SCORE_W = 10;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;
`ifdef GAME_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic               Clk = 1'b0;
    logic               Reset_n;
    logic               frame_tick;
    logic               start_key;
    logic               collision;
    logic [9:0]         pipe_x;
    logic [1:0]         state;
    logic               run_en;
    logic               obj_reset;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               game_over;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 idle, 1 play, 2 dying, 3 over
    int m_mode, m_score, m_high, m_frames_left, m_last_x;
    bit m_held, m_obj;

    game_controller #(
        .DEATH_FRAMES (8'(DF)),
        .SCORE_W      (SCORE_W),
        .PASS_X       (10'd265)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .start_key  (start_key),
        .collision  (collision),
        .pipe_x     (pipe_x),
        .state      (state),
        .run_en     (run_en),
        .obj_reset  (obj_reset),
        .score      (score),
        .high_score (high_score),
        .game_over  (game_over)
    );

    always #5 Clk = ~Clk;

    task automatic model_step();
        bit rise;
        rise   = start_key && !m_held;
        m_held = start_key;
        m_obj  = 1'b0;
        if (!Reset_n) begin
            m_mode = 0; m_score = 0; m_high = 0; m_frames_left = 0;
            m_last_x = 0; m_held = 1'b1;
            return;
        end
        if (m_mode == 0 || m_mode == 3) begin
            if (rise) begin m_mode = 1; m_obj = 1'b1; m_score = 0; end
        end else if (m_mode == 1) begin
            if (collision) begin
                m_mode = 2; m_frames_left = DF;
            end else if (frame_tick && m_last_x >= 265 && int'(pipe_x) < 265 && m_score < SCORE_MAX) begin
                m_score = m_score + 1;
            end
        end else if (frame_tick) begin
            m_frames_left = m_frames_left - 1;
            if (m_frames_left == 0) begin
                m_mode = 3;
                if (HS_EN && m_score > m_high) m_high = m_score;
            end
        end
        if (frame_tick) m_last_x = int'(pipe_x);
    endtask

    task automatic step();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic start_game();
        start_key = 1'b0; step();
        start_key = 1'b1; step();
        start_key = 1'b0;
    endtask

    task automatic cross_n(input int n);
        frame_tick = 1'b1;
        for (int i = 0; i < n; i++) begin
            pipe_x = 10'd270; step();
            pipe_x = 10'd260; step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic die();
        collision = 1'b1; step(); collision = 1'b0;
        for (int i = 0; i < DF; i++) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; start_key = 1'b1; frame_tick = 1'b0; collision = 1'b0; pipe_x = 10'd0;
        step(); step();
        Reset_n = 1'b1; step(); step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL held_key_state got %0d want 0", state); end
        checks++; if ({run_en, obj_reset, game_over} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {run_en, obj_reset, game_over}); end
        checks++; if (score !== '0 || high_score !== '0) begin errors++; $display("FAIL reset_scores got %0d/%0d want 0/0", score, high_score); end
        start_game();
        checks++; if (state !== 2'd1 || obj_reset !== 1'b1 || run_en !== 1'b1) begin errors++; $display("FAIL start got state %0d obj %b run %b want 1 1 1", state, obj_reset, run_en); end
        checks++; if (score !== '0) begin errors++; $display("FAIL start_score got %0d want 0", score); end
        step();
        checks++; if (obj_reset !== 1'b0) begin errors++; $display("FAIL obj_reset_width got %b want 0", obj_reset); end
    endtask

    task automatic test_scoring();
        frame_tick = 1'b1; pipe_x = 10'd270; step();
        frame_tick = 1'b0; pipe_x = 10'd260; step();
        checks++; if (score !== 10'd0) begin errors++; $display("FAIL no_tick_no_score got %0d want 0", score); end
        frame_tick = 1'b1; step();
        checks++; if (score !== 10'd1) begin errors++; $display("FAIL first_crossing got %0d want 1", score); end
        pipe_x = 10'd5; step();
        pipe_x = 10'd639; step();
        frame_tick = 1'b0;
        checks++; if (score !== 10'd1 || state !== 2'd1) begin errors++; $display("FAIL wrap_no_count got score %0d state %0d want 1 1", score, state); end
    endtask

    task automatic test_collision_crossing();
        frame_tick = 1'b1; pipe_x = 10'd270; step();
        pipe_x = 10'd260; collision = 1'b1; step();
        frame_tick = 1'b0; collision = 1'b0;
        checks++; if (state !== 2'd2 || run_en !== 1'b0) begin errors++; $display("FAIL collision got state %0d run %b want 2 0", state, run_en); end
        checks++; if (score !== 10'd1) begin errors++; $display("FAIL collision_wins got %0d want 1", score); end
    endtask

    task automatic test_dying();
        start_key = 1'b1; step();
        collision = 1'b1; step();
        start_key = 1'b0; collision = 1'b0; step();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL dying_ignores_inputs got %0d want 2", state); end
        for (int i = 1; i <= DF; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0;
            if (i < DF) begin
                checks++; if (state !== 2'd2) begin errors++; $display("FAIL dying_tick%0d got %0d want 2", i, state); end
                step();
            end
        end
        checks++; if (state !== 2'd3 || game_over !== 1'b1 || run_en !== 1'b0) begin errors++; $display("FAIL over got state %0d go %b run %b want 3 1 0", state, game_over, run_en); end
        checks++; if (high_score !== (HS_EN ? 10'd1 : 10'd0)) begin errors++; $display("FAIL high_first got %0d want %0d", high_score, HS_EN ? 1 : 0); end
    endtask

    task automatic test_high_score();
        start_game();
        checks++; if (state !== 2'd1 || obj_reset !== 1'b1 || score !== '0) begin errors++; $display("FAIL restart got state %0d obj %b score %0d want 1 1 0", state, obj_reset, score); end
        cross_n(4); die();
        checks++; if (high_score !== (HS_EN ? 10'd4 : 10'd0)) begin errors++; $display("FAIL high_4 got %0d want %0d", high_score, HS_EN ? 4 : 0); end
        start_game(); cross_n(7);
        checks++; if (score !== 10'd7) begin errors++; $display("FAIL score_7 got %0d want 7", score); end
        die();
        checks++; if (state !== 2'd3 || high_score !== (HS_EN ? 10'd7 : 10'd0)) begin errors++; $display("FAIL high_7 got state %0d high %0d want 3 %0d", state, high_score, HS_EN ? 7 : 0); end
        start_game(); cross_n(2); die();
        checks++; if (score !== 10'd2 || high_score !== (HS_EN ? 10'd7 : 10'd0)) begin errors++; $display("FAIL high_keep got score %0d high %0d want 2 %0d", score, high_score, HS_EN ? 7 : 0); end
    endtask

    task automatic test_saturation();
        start_game(); cross_n(SCORE_MAX + 2);
        checks++; if (score !== SCORE_W'(SCORE_MAX)) begin errors++; $display("FAIL saturate got %0d want %0d", score, SCORE_MAX); end
        cross_n(1);
        checks++; if (score !== SCORE_W'(SCORE_MAX)) begin errors++; $display("FAIL saturate_hold got %0d want %0d", score, SCORE_MAX); end
        die();
        checks++; if (high_score !== (HS_EN ? SCORE_W'(SCORE_MAX) : '0)) begin errors++; $display("FAIL high_max got %0d want %0d", high_score, HS_EN ? SCORE_MAX : 0); end
    endtask

    task automatic test_reset_in_dying();
        start_game();
        collision = 1'b1; step(); collision = 1'b0;
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pre_reset_dying got %0d want 2", state); end
        Reset_n = 1'b0; step();
        checks++; if (state !== 2'd0 || {run_en, obj_reset, game_over} !== 3'b000) begin errors++; $display("FAIL mid_reset got state %0d flags %b want 0 000", state, {run_en, obj_reset, game_over}); end
        checks++; if (score !== '0 || high_score !== '0) begin errors++; $display("FAIL mid_reset_scores got %0d/%0d want 0/0", score, high_score); end
        Reset_n = 1'b1; step();
        checks++; if (state !== 2'd0 || obj_reset !== 1'b0) begin errors++; $display("FAIL post_reset got state %0d obj %b want 0 0", state, obj_reset); end
    endtask

    task automatic test_random();
        int px;
        px = 300;
        for (int c = 0; c < 4000; c++) begin
            Reset_n    = ($urandom_range(0, 399) != 0);
            frame_tick = ($urandom_range(0, 1) == 1);
            collision  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) start_key = ~start_key;
            if (frame_tick) begin
                px = px - int'($urandom_range(1, 6));
                if (px < 240) px = 300;
            end
            pipe_x = 10'(px);
            step();
            checks++;
            if (state !== 2'(m_mode) || run_en !== (m_mode == 1) || obj_reset !== m_obj ||
                score !== SCORE_W'(m_score) || high_score !== SCORE_W'(m_high) || game_over !== (m_mode == 3)) begin
                errors++;
                $display("FAIL random_cycle%0d got st %0d run %b obj %b sc %0d hi %0d go %b want st %0d run %b obj %b sc %0d hi %0d go %b",
                         c, state, run_en, obj_reset, score, high_score, game_over,
                         m_mode, m_mode == 1, m_obj, m_score, m_high, m_mode == 3);
            end
        end
        Reset_n = 1'b1; collision = 1'b0; frame_tick = 1'b0;
    endtask

    initial begin
        m_mode = 0; m_score = 0; m_high = 0; m_frames_left = 0; m_last_x = 0;
        m_held = 1'b1; m_obj = 1'b0;
        test_reset();
        test_scoring();
        test_collision_crossing();
        test_dying();
        test_high_score();
        test_saturation();
        test_reset_in_dying();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
